// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the EX stage.
//   Multiply: full 2*WIDTH-bit product, ready MUL_LAT cycles after the start is captured.
//   Divide:   radix-2 restoring, quotient truncates toward zero, remainder follows the
//             dividend sign; ready WIDTH+2 cycles after the start is captured.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request, sampled only while busy=0
//   is_div          1=divide, 0=multiply (sampled with start)
//   is_signed       1=two's-complement operands (sampled with start)
//   cancel          abort the in-flight op
//   opa, opb        multiplicand/dividend, multiplier/divisor
//   busy            op in flight, high through the ready cycle
//   ready           one-cycle completion pulse
//   hi, lo          product[2W-1:W]/remainder, product[W-1:0]/quotient
//   div_by_zero     set with ready on a zero divisor, cleared on the next accepted start
module muldiv_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MUL_LAST = (MUL_LAT >= 2) ? CW'(MUL_LAT - 2) : '0;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DITER,
    DFIX,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;

  logic             w_accept;
  logic             w_load_res;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic             w_msg;
  logic [2*WIDTH-1:0] w_pa;
  logic [2*WIDTH-1:0] w_pb;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_accept = (r_state == IDLE) && start && !cancel;
  assign busy     = (r_state != IDLE);
  assign ready    = (r_state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && !cancel) begin
          if (is_div)            w_next = DITER;
          else if (MUL_LAT == 1) w_next = DONE;
          else                   w_next = MUL;
        end
      end
      MUL: begin
        if (cancel)                 w_next = IDLE;
        else if (r_cnt == MUL_LAST) w_next = DONE;
      end
      DITER: begin
        if (cancel)                 w_next = IDLE;
        else if (r_cnt == DIV_LAST) w_next = DFIX;
      end
      DFIX: begin
        if (cancel) w_next = IDLE;
        else        w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results are written only on the edge that enters DONE.
  assign w_load_res = (r_state != DONE) && (w_next == DONE);

  // Multiplier operands come straight from the ports in IDLE so MUL_LAT=1 works.
  assign w_ma   = (r_state == IDLE) ? opa       : r_a;
  assign w_mb   = (r_state == IDLE) ? opb       : r_b;
  assign w_msg  = (r_state == IDLE) ? is_signed : r_sgn;
  assign w_pa   = {{WIDTH{w_msg & w_ma[WIDTH-1]}}, w_ma};
  assign w_pb   = {{WIDTH{w_msg & w_mb[WIDTH-1]}}, w_mb};
  assign w_prod = w_pa * w_pb;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_abs_a = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign w_abs_b = (is_signed && opb[WIDTH-1]) ? -opb : opb;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_state == DFIX) begin
      if (r_dz) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_rneg ? -r_rem : r_rem;
        w_res_lo = r_qneg ? -r_quo : r_quo;
      end
    end
  end

  // Datapath. Magnitudes and sign flags are taken at acceptance so the
  // divide preparation overlaps the start edge and the iterations begin at T+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sgn       <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt       <= '0;
        r_a         <= opa;
        r_b         <= opb;
        r_sgn       <= is_signed;
        r_rem       <= '0;
        r_quo       <= w_abs_a;
        r_dvs       <= w_abs_b;
        r_qneg      <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_rneg      <= is_signed & opa[WIDTH-1];
        r_dz        <= (opb == '0);
        div_by_zero <= 1'b0;
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == DITER) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end
      if (w_load_res) begin
        hi          <= w_res_hi;
        lo          <= w_res_lo;
        div_by_zero <= (r_state == DFIX) && r_dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_div, is_signed, cancel;
  logic [31:0] opa, opb;
  logic        busy, ready, div_by_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div), .is_signed(is_signed),
    .cancel(cancel), .opa(opa), .opb(opb), .busy(busy), .ready(ready),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic void ref_op(input logic d, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] h,
                                 output logic [31:0] l, output logic z);
    longint sa, sb, p;
    logic [63:0] up;
    z = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      if (s) begin p = sa * sb; {h, l} = p; end
      else begin up = {32'h0, a} * {32'h0, b}; {h, l} = up; end
    end else if (b == 32'h0) begin
      z = 1'b1; l = 32'hFFFF_FFFF; h = a;
    end else if (s) begin
      l = 32'(sa / sb); h = 32'(sa % sb);
    end else begin
      l = a / b; h = a % b;
    end
  endfunction

  // Behavioural model: age of the op in flight and the result it will deliver.
  logic        m_valid = 1'b0;
  int          m_age = 0, m_lat = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_dbz, p_dbz;
  logic        m_busy, m_ready;

  always @(posedge clk) begin : model
    logic [31:0] th, tl;
    logic        tz;
    if (rst) begin
      m_valid <= 1'b1; m_age <= 0; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
    end else if (m_age > 0) begin
      if (m_age == m_lat)  m_age <= 0;
      else if (cancel)     m_age <= 0;
      else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat) begin m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz; end
      end
    end else if (start && !cancel) begin
      ref_op(is_div, is_signed, opa, opb, th, tl, tz);
      p_hi <= th; p_lo <= tl; p_dbz <= tz;
      m_dbz <= 1'b0;
      m_lat <= is_div ? 34 : 2;
      m_age <= 1;
    end
  end

  assign m_busy  = (m_age > 0);
  assign m_ready = (m_age > 0) && (m_age == m_lat);

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",  {31'b0, busy},  {31'b0, m_busy});
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait for its ready pulse; returns with the bench in the ready cycle.
  task automatic run_op(input logic d, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    int t0;
    lat = -1;
    @(negedge clk);
    is_div = d; is_signed = s; opa = a; opb = b; start = 1'b1; t0 = cyc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom;
      if (ready) begin lat = cyc - t0; break; end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got none expected pulse within 50 cycles");
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int lat, t0, nrdy;
    logic [31:0] prev_hi, prev_lo;
    rst = 1'b1; start = 1'b0; is_div = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat);
    chk("div100_7 latency", lat, 32'd34);
    chk("div100_7 lo", lo, 32'd14);
    chk("div100_7 hi", hi, 32'd2);
    chk("div100_7 dbz", {31'b0, div_by_zero}, 32'd0);

    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("sdiv -7/2 lo", lo, 32'hFFFF_FFFD);
    chk("sdiv -7/2 hi", hi, 32'hFFFF_FFFF);

    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("sdiv min/-1 lo", lo, 32'h8000_0000);
    chk("sdiv min/-1 hi", hi, 32'h0);

    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, lat);
    chk("smul latency", lat, 32'd2);
    chk("smul hi", hi, 32'hFFFF_FFFF);
    chk("smul lo", lo, 32'hFFFF_FFFE);

    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, lat);
    chk("umul hi", hi, 32'h1);
    chk("umul lo", lo, 32'hFFFF_FFFE);

    run_op(1'b1, 1'b0, 32'd5, 32'd0, lat);
    chk("div5_0 latency", lat, 32'd34);
    chk("div5_0 lo", lo, 32'hFFFF_FFFF);
    chk("div5_0 hi", hi, 32'd5);
    chk("div5_0 dbz", {31'b0, div_by_zero}, 32'd1);
    @(negedge clk);
    chk("dbz held while idle", {31'b0, div_by_zero}, 32'd1);
    is_div = 1'b0; is_signed = 1'b0; opa = 32'd3; opb = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dbz cleared on start", {31'b0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);

    // Cancel mid-divide, then restart in the cycle busy drops.
    prev_hi = hi; prev_lo = lo; nrdy = 0;
    is_div = 1'b1; is_signed = 1'b0; opa = 32'd1000; opb = 32'd3; start = 1'b1; t0 = cyc;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      cancel = (cyc - t0 == 10);
      if (ready) nrdy++;
    end
    cancel = 1'b0;
    chk("cancel busy", {31'b0, busy}, 32'd0);
    chk("cancel no ready", nrdy, 32'd0);
    chk("cancel keeps lo", lo, prev_lo);
    chk("cancel keeps hi", hi, prev_hi);
    is_div = 1'b1; is_signed = 1'b1; opa = 32'd9; opb = 32'hFFFF_FFFC; start = 1'b1; t0 = cyc;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) begin lat = cyc - t0; break; end
    end
    chk("restart latency", lat, 32'd34);
    chk("restart lo", lo, 32'hFFFF_FFFE);
    chk("restart hi", hi, 32'd1);

    // Start pulsed while busy is ignored.
    @(negedge clk);
    is_div = 1'b1; is_signed = 1'b0; opa = 32'd100; opb = 32'd7; start = 1'b1; t0 = cyc; nrdy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 5); is_div = (k == 5) ? 1'b0 : 1'b1;
      if (ready) nrdy++;
    end
    start = 1'b0;
    chk("one ready pulse", nrdy, 32'd1);
    chk("ignored start lo", lo, 32'd14);

    // start and cancel together in IDLE: nothing starts.
    start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start+cancel idle", {31'b0, busy}, 32'd0);

    // Reset mid-divide.
    is_div = 1'b1; opa = 32'd77; opb = 32'd5; start = 1'b1; t0 = cyc;
    repeat (20) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst ready", {31'b0, ready}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst dbz", {31'b0, div_by_zero}, 32'd0);

    // Randomized traffic with cancels and stray starts.
    for (int n = 0; n < 150; n++) begin
      int cmode, cat;
      bit done;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      is_div = 1'($urandom_range(0, 1)); is_signed = 1'($urandom_range(0, 1));
      opa = pick(); opb = pick(); start = 1'b1;
      cmode = $urandom_range(0, 5);
      cancel = (cmode == 2);
      cat = is_div ? $urandom_range(1, 34) : $urandom_range(1, 2);
      done = 1'b0;
      for (int k = 1; k < 60; k++) begin
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; opa = $urandom; opb = $urandom;
        if (!m_busy) begin done = 1'b1; break; end
        if (cmode == 0 && k == cat) cancel = 1'b1;
        if (cmode == 1 && k == cat) begin
          start = 1'b1; is_div = 1'($urandom_range(0, 1));
        end
      end
      if (!done) begin
        n_tests++; n_fail++;
        $display("FAIL random_timeout: got busy expected idle within 60 cycles (op %0d)", n);
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
